// File: rtl/ved_mult_pipe.sv
// Three-stage pipelined signed/unsigned multiplier built from recursive Vedic
// (Urdhva Tiryagbhyam) cross-multiply cells, with a valid/ready stall handshake.

// Recursive N x N Vedic cell: four N/2 sub-products recombined, 2x2 at the leaf.
module ved_mult_cell #(
  parameter int N = 2
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);

  localparam int PW = 2 * N;

  if (N == 2) begin : g_leaf
    logic t_hl, t_lh, t_hh, c_1;

    // Leaf: four AND terms; two half adders fold the cross terms and the carry.
    assign p[0] = x[0] & y[0];
    assign t_hl = x[1] & y[0];
    assign t_lh = x[0] & y[1];
    assign t_hh = x[1] & y[1];
    assign p[1] = t_hl ^ t_lh;
    assign c_1  = t_hl & t_lh;
    assign p[2] = t_hh ^ c_1;
    assign p[3] = t_hh & c_1;
  end else begin : g_node
    localparam int M = N / 2;

    logic [N-1:0] pp_ll, pp_hl, pp_lh, pp_hh;
    logic [N+1:0] mid_sum;

    ved_mult_cell #(.N(M)) u_ll (.x(x[M-1:0]), .y(y[M-1:0]), .p(pp_ll));
    ved_mult_cell #(.N(M)) u_hl (.x(x[N-1:M]), .y(y[M-1:0]), .p(pp_hl));
    ved_mult_cell #(.N(M)) u_lh (.x(x[M-1:0]), .y(y[N-1:M]), .p(pp_lh));
    ved_mult_cell #(.N(M)) u_hh (.x(x[N-1:M]), .y(y[N-1:M]), .p(pp_hh));

    assign mid_sum = {2'b00, pp_hl} + {2'b00, pp_lh};
    assign p       = {pp_hh, pp_ll} + (PW'(mid_sum) << M);
  end

endmodule

// Pipeline top. WIDTH must be 4, 8, 16 or 32 so every recursion level halves evenly.
module ved_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int H  = WIDTH / 2;
  localparam int RW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [RW-1:0]    ONE_R = RW'(1);

  logic adv;

  // Stage 1: operand magnitudes, signs and mode.
  logic             s1_valid_q,  s1_valid_d;
  logic [WIDTH-1:0] s1_mag_a_q,  s1_mag_a_d;
  logic [WIDTH-1:0] s1_mag_b_q,  s1_mag_b_d;
  logic             s1_sign_a_q, s1_sign_a_d;
  logic             s1_sign_b_q, s1_sign_b_d;
  logic             s1_mode_q,   s1_mode_d;

  // Stage 2: half-width partial products and the final sign decision.
  logic             s2_valid_q,  s2_valid_d;
  logic [WIDTH-1:0] s2_pp_ll_q,  s2_pp_ll_d;
  logic [WIDTH-1:0] s2_pp_hl_q,  s2_pp_hl_d;
  logic [WIDTH-1:0] s2_pp_lh_q,  s2_pp_lh_d;
  logic [WIDTH-1:0] s2_pp_hh_q,  s2_pp_hh_d;
  logic             s2_neg_q,    s2_neg_d;

  // Stage 3: output registers.
  logic             out_valid_q, out_valid_d;
  logic [RW-1:0]    result_q,    result_d;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] pp_ll, pp_hl, pp_lh, pp_hh;
  logic [WIDTH+1:0] mid_sum;
  logic [RW-1:0]    prod_mag, prod_signed;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  assign neg_a = signed_mode & a[WIDTH-1];
  assign neg_b = signed_mode & b[WIDTH-1];
  assign mag_a = neg_a ? (~a + ONE_W) : a;
  assign mag_b = neg_b ? (~b + ONE_W) : b;

  ved_mult_cell #(.N(H)) u_pp_ll (.x(s1_mag_a_q[H-1:0]),     .y(s1_mag_b_q[H-1:0]),     .p(pp_ll));
  ved_mult_cell #(.N(H)) u_pp_hl (.x(s1_mag_a_q[WIDTH-1:H]), .y(s1_mag_b_q[H-1:0]),     .p(pp_hl));
  ved_mult_cell #(.N(H)) u_pp_lh (.x(s1_mag_a_q[H-1:0]),     .y(s1_mag_b_q[WIDTH-1:H]), .p(pp_lh));
  ved_mult_cell #(.N(H)) u_pp_hh (.x(s1_mag_a_q[WIDTH-1:H]), .y(s1_mag_b_q[WIDTH-1:H]), .p(pp_hh));

  // Negating a zero magnitude yields zero, so no special case is needed.
  assign mid_sum     = {2'b00, s2_pp_hl_q} + {2'b00, s2_pp_lh_q};
  assign prod_mag    = {s2_pp_hh_q, s2_pp_ll_q} + (RW'(mid_sum) << H);
  assign prod_signed = s2_neg_q ? (~prod_mag + ONE_R) : prod_mag;

  always_comb begin
    // NOTE: every _d takes its _q as a default first, so a stalled stage holds
    // without an else branch and no latch can be inferred.
    adv         = !out_valid_q || out_ready;
    s1_valid_d  = s1_valid_q;
    s1_mag_a_d  = s1_mag_a_q;
    s1_mag_b_d  = s1_mag_b_q;
    s1_sign_a_d = s1_sign_a_q;
    s1_sign_b_d = s1_sign_b_q;
    s1_mode_d   = s1_mode_q;
    s2_valid_d  = s2_valid_q;
    s2_pp_ll_d  = s2_pp_ll_q;
    s2_pp_hl_d  = s2_pp_hl_q;
    s2_pp_lh_d  = s2_pp_lh_q;
    s2_pp_hh_d  = s2_pp_hh_q;
    s2_neg_d    = s2_neg_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;

    if (adv) begin
      s1_valid_d  = in_valid && adv;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;

      // Payloads only move with a valid bit, so idle inputs and bubbles leave data untouched.
      if (in_valid) begin
        s1_mag_a_d  = mag_a;
        s1_mag_b_d  = mag_b;
        s1_sign_a_d = neg_a;
        s1_sign_b_d = neg_b;
        s1_mode_d   = signed_mode;
      end
      if (s1_valid_q) begin
        s2_pp_ll_d = pp_ll;
        s2_pp_hl_d = pp_hl;
        s2_pp_lh_d = pp_lh;
        s2_pp_hh_d = pp_hh;
        s2_neg_d   = s1_mode_q & (s1_sign_a_q ^ s1_sign_b_q);
      end
      if (s2_valid_q) begin
        result_d = prod_signed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  // NOTE: datapath stage registers carry no reset; their contents are only
  // consumed when the matching valid bit, which does reset, is set.
  always_ff @(posedge clk) begin
    s1_mag_a_q  <= s1_mag_a_d;
    s1_mag_b_q  <= s1_mag_b_d;
    s1_sign_a_q <= s1_sign_a_d;
    s1_sign_b_q <= s1_sign_b_d;
    s1_mode_q   <= s1_mode_d;
    s2_pp_ll_q  <= s2_pp_ll_d;
    s2_pp_hl_q  <= s2_pp_hl_d;
    s2_pp_lh_q  <= s2_pp_lh_d;
    s2_pp_hh_q  <= s2_pp_hh_d;
    s2_neg_q    <= s2_neg_d;
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: doc/ved_mult_pipe.md
VED_MULT_PIPE -- requirements
Module: ved_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; legal values 4, 8, 16, 32.
REQ-002 SHALL have clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have rst  input  1  reset; the block uses one clock, and reset is synchronous and active-high.
REQ-004 SHALL have in_valid  input  1  operand pair present.
REQ-005 SHALL have in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have a  input  WIDTH  multiplicand.
REQ-007 SHALL have b  input  WIDTH  multiplier.
REQ-008 SHALL have signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-009 SHALL have out_valid  output  1  result present.
REQ-010 SHALL have out_ready  input  1  consumer accepts result.
REQ-011 SHALL have result  output  2*WIDTH  product.

Function
REQ-012 SHALL compute result = a*b exactly over 2*WIDTH bits, interpreted per the signed_mode value captured with that operand pair.
REQ-013 SHALL be a 3-stage pipeline: S1 registers operand magnitudes, operand signs and mode; S2 registers the four half-width Vedic partial products (aL*bL, aH*bL, aL*bH, aH*bH); S3 registers the combined and sign-corrected result.
REQ-014 SHALL build each half-width partial product recursively from Vedic cross-multiply blocks, down to the 2x2 leaf: AND gates plus two half adders.
REQ-015 S1 SHALL, in signed mode, convert each negative operand to its WIDTH-bit unsigned magnitude; -2^(WIDTH-1) SHALL map to magnitude 2^(WIDTH-1).
REQ-016 S3 SHALL negate the 2*WIDTH-bit magnitude when signed_mode=1 and exactly one operand is negative; a zero product SHALL never be negated to a non-zero value.
REQ-017 SHALL use the combine rule P = PP_HH<<WIDTH + (PP_HL+PP_LH)<<(WIDTH/2) + PP_LL, with intermediate sums at least WIDTH+2 bits wide so no carry is lost.
REQ-018 SHALL define an advance enable adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-019 An operand pair SHALL be accepted only on a cycle where in_valid && in_ready.
REQ-020 When adv=1, every stage SHALL shift forward one position, and each stage valid bit SHALL take the valid bit of the stage before it; S1 valid SHALL take in_valid && in_ready.
REQ-021 When adv=0, every stage register and valid bit SHALL hold its value.
REQ-022 Latency SHALL be 3 cycles from acceptance to out_valid with no backpressure; throughput SHALL be 1 result per cycle.
REQ-023 result and out_valid SHALL be driven directly from S3 registers, with no combinational path from a, b or signed_mode.
REQ-024 While out_valid=1 and out_ready=0, result SHALL stay stable until the handshake completes.
REQ-025 Results SHALL leave in acceptance order; no operand pair SHALL be dropped or duplicated.
REQ-026 A cycle with in_valid=0 and adv=1 SHALL insert a bubble; bubbles SHALL not produce out_valid.
REQ-027 Values on a, b or signed_mode in cycles with no acceptance SHALL have no effect.

Reset
REQ-028 When rst=1 at a clock edge, all stage valid bits SHALL clear, out_valid SHALL be 0 and result SHALL be 0, whatever the other inputs are.
REQ-029 Reset SHALL discard in-flight operations; no result from before reset SHALL appear afterwards.
REQ-030 in_ready SHALL be 1 in the first cycle after rst is released.
REQ-031 Data registers other than result need no reset value, but SHALL never raise out_valid without a valid bit.

Verification
REQ-032 WIDTH=8, unsigned, a=0xFF, b=0xFF, out_ready=1 -> result=0xFE01, out_valid 3 cycles after acceptance.
REQ-033 WIDTH=8, signed: -128*-128 -> 0x4000; -1*127 -> 0xFF81; -128*1 -> 0xFF80; 0*-5 -> 0x0000.
REQ-034 WIDTH=8, back-to-back stream of 0x00..0xFF times 0xFF with random out_ready -> all 256 results correct and in order; in_ready=0 exactly on cycles where out_valid=1 and out_ready=0.
REQ-035 out_ready=0 for 5 cycles with 3 operations in flight -> result holds; then 3 results appear on consecutive cycles once out_ready=1.
REQ-036 rst asserted for 1 cycle with 2 operations in flight -> out_valid=0 and result=0 next cycle; no stale result afterwards.
REQ-037 WIDTH=4, 16 and 32: random signed and unsigned operands plus corners (0, 1, max, min) checked against a reference multiply.
